// File: rtl/c_element_pkg.sv
// Shared types and helpers for the clocked N-input, M-channel Muller C-element.
// Channel vectors are carried in a fixed-width container; only the low n bits are significant.
package c_element_pkg;

  localparam int unsigned INPUTS_MAX = 16;
  localparam int unsigned CNT_W_DEF  = 8;
  // Counter saturation pattern; a CNT_W-wide slice of this is the all-ones limit.
  localparam logic [31:0] CNT_ONES   = 32'hFFFF_FFFF;

  typedef logic [INPUTS_MAX-1:0] ch_in_t;

  // C-element next state: set when all n inputs are 1, clear when all are 0, else hold.
  function automatic logic c_next(input ch_in_t in_v, input int unsigned n, input logic cur);
    logic all1;
    logic any1;
    all1 = 1'b1;
    any1 = 1'b0;
    for (int unsigned i = 0; i < INPUTS_MAX; i++) begin
      if (i < n) begin
        all1 = all1 & in_v[i];
        any1 = any1 | in_v[i];
      end else begin
        all1 = all1;
      end
    end
    if (all1) begin
      return 1'b1;
    end else if (!any1) begin
      return 1'b0;
    end else begin
      return cur;
    end
  endfunction

endpackage

// File: rtl/c_element_cell_m.sv
// One C-element channel: output state, rise/fall pulses and saturating transition counter.
// Optional 2-flop input synchroniser selected by C_ELEMENT_SYNC_EN.
module c_element_cell_m
  import c_element_pkg::*;
#(
  parameter int unsigned INPUTS  = 3,
  parameter int unsigned CNT_W   = 8,
  parameter logic        RST_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [INPUTS-1:0] a,
  input  logic              cnt_clr,
  output logic              o,
  output logic              o_nxt,
  output logic              rise,
  output logic              fall,
  output logic [CNT_W-1:0]  cnt
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_ONES[CNT_W-1:0];

  logic [INPUTS-1:0] a_use_s;
  ch_in_t            in_ext_s;
  logic              o_nxt_s;
  logic              trans_s;
  logic              o_r;
  logic              rise_r;
  logic              fall_r;
  logic [CNT_W-1:0]  cnt_r;

`ifdef C_ELEMENT_SYNC_EN
  logic [INPUTS-1:0] sync1_r;
  logic [INPUTS-1:0] sync2_r;

  // Two-stage synchroniser on every input bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= {INPUTS{1'b0}};
      sync2_r <= {INPUTS{1'b0}};
    end else begin
      sync1_r <= a;
      sync2_r <= sync1_r;
    end
  end

  assign a_use_s = sync2_r;
`else
  assign a_use_s = a;
`endif

  // Next-state of the C-element, frozen when the channel is disabled
  always_comb begin
    in_ext_s                = '0;
    in_ext_s[INPUTS-1:0]    = a_use_s;
    if (en) begin
      o_nxt_s = c_next(in_ext_s, INPUTS, o_r);
    end else begin
      o_nxt_s = o_r;
    end
    trans_s = o_nxt_s ^ o_r;
  end

  // Output state, edge pulses and counter; clear-then-count when both happen together
  always_ff @(posedge clk) begin
    if (rst) begin
      o_r    <= RST_BIT;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      o_r    <= o_nxt_s;
      rise_r <= o_nxt_s & ~o_r;
      fall_r <= ~o_nxt_s & o_r;
      if (cnt_clr) begin
        cnt_r <= trans_s ? CNT_W'(1) : {CNT_W{1'b0}};
      end else if (trans_s && (cnt_r != CNT_SAT)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign o     = o_r;
  assign o_nxt = o_nxt_s;
  assign rise  = rise_r;
  assign fall  = fall_r;
  assign cnt   = cnt_r;

endmodule

// File: rtl/c_element_n_m.sv
// CHANNELS independent INPUTS-input C-elements with registered rendezvous flags.
// Build option: define C_ELEMENT_SYNC_EN to add a 2-flop synchroniser on every input.
module c_element_n_m
  import c_element_pkg::*;
#(
  parameter int unsigned          CHANNELS = 4,
  parameter int unsigned          INPUTS   = 3,
  parameter int unsigned          CNT_W    = CNT_W_DEF,
  parameter logic [CHANNELS-1:0]  RST_VAL  = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CHANNELS-1:0]              en,
  input  logic [CHANNELS-1:0][INPUTS-1:0]  a,
  output logic [CHANNELS-1:0]              o,
  output logic [CHANNELS-1:0]              rise,
  output logic [CHANNELS-1:0]              fall,
  output logic                             all_set,
  output logic                             all_clr,
  output logic [CHANNELS-1:0][CNT_W-1:0]   cnt,
  input  logic [CHANNELS-1:0]              cnt_clr
);

  logic [CHANNELS-1:0] o_nxt_s;
  logic                all_set_r;
  logic                all_clr_r;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    c_element_cell_m #(
      .INPUTS  (INPUTS),
      .CNT_W   (CNT_W),
      .RST_BIT (RST_VAL[c])
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en[c]),
      .a       (a[c]),
      .cnt_clr (cnt_clr[c]),
      .o       (o[c]),
      .o_nxt   (o_nxt_s[c]),
      .rise    (rise[c]),
      .fall    (fall[c]),
      .cnt     (cnt[c])
    );
  end

  // Rendezvous flags from next-state o so they line up with o itself
  always_ff @(posedge clk) begin
    if (rst) begin
      all_set_r <= &RST_VAL;
      all_clr_r <= ~|RST_VAL;
    end else begin
      all_set_r <= &o_nxt_s;
      all_clr_r <= ~|o_nxt_s;
    end
  end

  assign all_set = all_set_r;
  assign all_clr = all_clr_r;

endmodule

// File: tb/tb_c_element_n_m.sv
// Scoreboard bench for c_element_n_m (CHANNELS=4, INPUTS=3, CNT_W=8, RST_VAL=4'b0101).
// Driver queues the hand-computed post-edge outputs; a monitor pops one entry per clock edge.
module tb_c_element_n_m;

  logic             clk;
  logic             rst;
  logic [3:0]       en;
  logic [3:0][2:0]  a;
  logic [3:0]       o;
  logic [3:0]       rise;
  logic [3:0]       fall;
  logic             all_set;
  logic             all_clr;
  logic [3:0][7:0]  cnt;
  logic [3:0]       cnt_clr;

  typedef struct packed {
    logic [3:0]  o;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic        aset;
    logic        aclr;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  c_element_n_m #(
    .CHANNELS (4),
    .INPUTS   (3),
    .CNT_W    (8),
    .RST_VAL  (4'b0101)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .a       (a),
    .o       (o),
    .rise    (rise),
    .fall    (fall),
    .all_set (all_set),
    .all_clr (all_clr),
    .cnt     (cnt),
    .cnt_clr (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pk(input logic [2:0] a3, input logic [2:0] a2,
                                     input logic [2:0] a1, input logic [2:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [31:0] cv(input int c3, input int c2, input int c1, input int c0);
    return {c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
  endfunction

  // Drive one cycle of stimulus and queue what must appear after the next edge
  task automatic vec(input logic r, input logic [3:0] e, input logic [11:0] av,
                     input logic [3:0] cl, input logic [3:0] eo, input logic [3:0] er,
                     input logic [3:0] ef, input logic es, input logic ec, input logic [31:0] ecnt);
    exp_t x;
    @(negedge clk);
    rst     = r;
    en      = e;
    a       = av;
    cnt_clr = cl;
    x.o = eo; x.rise = er; x.fall = ef; x.aset = es; x.aclr = ec; x.cnt = ecnt;
    exp_q.push_back(x);
  endtask

  // Monitor: one expected entry per edge, sampled 2 time units after it
  always @(posedge clk) begin
    exp_t x;
    #2;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      total++;
      if ({o, rise, fall, all_set, all_clr} !== {x.o, x.rise, x.fall, x.aset, x.aclr}) begin
        bad++;
        $display("FAIL flags t=%0t: got o=%b rise=%b fall=%b all_set=%b all_clr=%b, want o=%b rise=%b fall=%b all_set=%b all_clr=%b",
                 $time, o, rise, fall, all_set, all_clr, x.o, x.rise, x.fall, x.aset, x.aclr);
      end
      total++;
      if (cnt !== x.cnt) begin
        bad++;
        $display("FAIL cnt t=%0t: got %h want %h", $time, cnt, x.cnt);
      end
    end
  end

  initial begin
    rst     = 1'b1;
    en      = 4'b1111;
    a       = '0;
    cnt_clr = 4'b0000;

`ifdef C_ELEMENT_SYNC_EN
    vec(1'b1, 4'b1111, pk(3'b000,3'b000,3'b000,3'b000), 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0, cv(0,0,0,0));
    vec(1'b1, 4'b1111, pk(3'b000,3'b000,3'b000,3'b000), 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0, cv(0,0,0,0));
    vec(1'b0, 4'b1111, pk(3'b000,3'b000,3'b000,3'b000), 4'b0000, 4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b1, cv(0,1,0,1));
    // a[0]=111 appears on o three edges later
    vec(1'b0, 4'b1111, pk(3'b000,3'b000,3'b000,3'b111), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, cv(0,1,0,1));
    vec(1'b0, 4'b1111, pk(3'b000,3'b000,3'b000,3'b111), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, cv(0,1,0,1));
    vec(1'b0, 4'b1111, pk(3'b000,3'b000,3'b000,3'b111), 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, cv(0,1,0,2));
    vec(1'b0, 4'b1111, pk(3'b000,3'b000,3'b000,3'b111), 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, cv(0,1,0,2));
`else
    // reset to 0101, then channels 0 and 2 fall
    vec(1'b1, 4'b1111, pk(3'b000,3'b000,3'b000,3'b000), 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0, cv(0,0,0,0));
    vec(1'b1, 4'b1111, pk(3'b000,3'b000,3'b000,3'b000), 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0, cv(0,0,0,0));
    vec(1'b0, 4'b1111, pk(3'b000,3'b000,3'b000,3'b000), 4'b0000, 4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b1, cv(0,1,0,1));
    // channel 1: mixed holds, all-1 rises, mixed holds, all-0 falls
    vec(1'b0, 4'b1111, pk(3'b000,3'b000,3'b110,3'b000), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, cv(0,1,0,1));
    vec(1'b0, 4'b1111, pk(3'b000,3'b000,3'b111,3'b000), 4'b0000, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, cv(0,1,1,1));
    vec(1'b0, 4'b1111, pk(3'b000,3'b000,3'b111,3'b000), 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, cv(0,1,1,1));
    vec(1'b0, 4'b1111, pk(3'b000,3'b000,3'b011,3'b000), 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, cv(0,1,1,1));
    vec(1'b0, 4'b1111, pk(3'b000,3'b000,3'b000,3'b000), 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b1, cv(0,1,2,1));
    // channel 2 disabled with all-1 inputs, then enabled
    vec(1'b0, 4'b1011, pk(3'b000,3'b111,3'b000,3'b000), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, cv(0,1,2,1));
    vec(1'b0, 4'b1011, pk(3'b000,3'b111,3'b000,3'b000), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, cv(0,1,2,1));
    vec(1'b0, 4'b1111, pk(3'b000,3'b111,3'b000,3'b000), 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, cv(0,2,2,1));
    // staggered rendezvous: all_set only once the last channel rises
    vec(1'b0, 4'b1111, pk(3'b000,3'b111,3'b000,3'b111), 4'b0000, 4'b0101, 4'b0001, 4'b0000, 1'b0, 1'b0, cv(0,2,2,2));
    vec(1'b0, 4'b1111, pk(3'b000,3'b111,3'b111,3'b111), 4'b0000, 4'b0111, 4'b0010, 4'b0000, 1'b0, 1'b0, cv(0,2,3,2));
    vec(1'b0, 4'b1111, pk(3'b111,3'b111,3'b111,3'b111), 4'b0000, 4'b1111, 4'b1000, 4'b0000, 1'b1, 1'b0, cv(1,2,3,2));
    vec(1'b0, 4'b1111, pk(3'b111,3'b111,3'b111,3'b111), 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, cv(1,2,3,2));
    // mid-sequence reset: back to 0101 with no pulses, then normal pulses relative to 0101
    vec(1'b1, 4'b1111, pk(3'b111,3'b111,3'b111,3'b111), 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0, cv(0,0,0,0));
    vec(1'b0, 4'b1111, pk(3'b111,3'b111,3'b111,3'b111), 4'b0000, 4'b1111, 4'b1010, 4'b0000, 1'b1, 1'b0, cv(1,0,1,0));
    vec(1'b0, 4'b1111, pk(3'b000,3'b000,3'b000,3'b000), 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, cv(2,1,2,1));
    // channel 3 toggles every cycle; counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      int c3;
      logic odd;
      odd = i[0];
      c3  = (i + 3 > 255) ? 255 : i + 3;
      vec(1'b0, 4'b1111, pk(odd ? 3'b000 : 3'b111, 3'b000, 3'b000, 3'b000), 4'b0000,
          {~odd, 3'b000}, {~odd, 3'b000}, {odd, 3'b000}, 1'b0, odd, cv(c3, 1, 2, 1));
    end
    // clear on a transition cycle counts 1; clear without one gives 0
    vec(1'b0, 4'b1111, pk(3'b111,3'b000,3'b000,3'b000), 4'b1000, 4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0, cv(1,1,2,1));
    vec(1'b0, 4'b1111, pk(3'b111,3'b000,3'b000,3'b000), 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, cv(0,1,2,1));
    // a[0]=111 shows on o one edge later
    vec(1'b0, 4'b1111, pk(3'b111,3'b000,3'b000,3'b111), 4'b0001, 4'b1001, 4'b0001, 4'b0000, 1'b0, 1'b0, cv(0,1,2,1));
    vec(1'b0, 4'b1111, pk(3'b111,3'b000,3'b000,3'b111), 4'b0001, 4'b1001, 4'b0000, 4'b0000, 1'b0, 1'b0, cv(0,1,2,0));
    vec(1'b0, 4'b1111, pk(3'b111,3'b000,3'b101,3'b111), 4'b0000, 4'b1001, 4'b0000, 4'b0000, 1'b0, 1'b0, cv(0,1,2,0));
`endif

    repeat (3) @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c_element_n_m.md
Name: c_element_n_m

Overview:
- Clocked, parametrised successor to the two-input Muller C-element `c_element_m`.
- Provides CHANNELS independent C-elements, each with INPUTS symmetric inputs and a per-channel enable.
- Each channel has a programmable reset value, rise/fall event pulses and a saturating event counter.
- Sits at synchronous handshake join points, e.g. pipeline-stage rendezvous and multi-source request merge.

Parameters:
- CHANNELS, 4, number of independent C-element channels (>=1)
- INPUTS, 3, symmetric inputs per channel (>=2)
- CNT_W, 8, width of per-channel transition counter
- RST_VAL, '0 (CHANNELS bits), reset value of each channel output

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- en  input  CHANNELS  per-channel update enable; 0 freezes that channel
- a  input  CHANNELS x INPUTS  packed 2D array; a[c][i] is input i of channel c
- o  output  CHANNELS  C-element outputs
- rise  output  CHANNELS  one-cycle pulse when o[c] goes 0->1
- fall  output  CHANNELS  one-cycle pulse when o[c] goes 1->0
- all_set  output  1  registered AND of o (rendezvous complete)
- all_clr  output  1  registered NOR of o
- cnt  output  CHANNELS x CNT_W  per-channel count of output transitions, saturating
- cnt_clr  input  CHANNELS  per-channel synchronous counter clear

Behaviour:
- Reset (rst=1 at clk edge) forces:
  - o=RST_VAL; rise=0; fall=0; cnt=0
  - all_set and all_clr take the values computed from RST_VAL, not 0
  - rst has priority over en, cnt_clr and all inputs.
- Per channel c, each edge with en[c]=1:
  - all a[c][*]=1 -> o[c]<=1
  - all a[c][*]=0 -> o[c]<=0
  - otherwise hold.
- en[c]=0: o[c] holds and rise[c]/fall[c] are 0.
- Latency: 1 clock from stable input pattern to o.
- rise/fall:
  - Asserted in the same cycle the new o value first appears; they are registered, not derived from o combinationally.
  - Never both 1 for one channel.
  - Deasserted the following cycle unless another transition occurs; consecutive toggles are allowed.
- all_set/all_clr:
  - Computed from next-state o and registered, so aligned with o (same cycle).
  - Both 0 when the channels disagree.
- cnt[c]:
  - Increments on every rise or fall of channel c; saturates at 2^CNT_W-1, no wrap.
  - cnt_clr[c]=1 sets cnt[c]<=0; if a transition occurs in the same cycle, cnt[c]<=1 (clear then count).
- Reset mid-operation: the channel state is discarded with no pulse on the reset edge. The first post-reset transition relative to RST_VAL produces a normal pulse.
- No combinational path from a to any output.

Optional Feature:
- Macro: C_ELEMENT_SYNC_EN.
- Defined:
  - Each a[c][i] passes through a 2-flop synchroniser before the C-element logic; synchroniser flops reset to 0.
  - Input-to-o latency becomes 3 clocks; all other timing relationships are unchanged relative to o.
- Undefined: inputs are used directly; latency is 1 clock. Inputs must then be synchronous to clk.

Decomposition:
- Package c_element_pkg:
  - Typedef for the channel input vector, logic [INPUTS-1:0].
  - Function for C-element next-state, f(inputs, current) -> next.
  - Localparam for counter saturation value.
- Sub-module c_element_cell_m: one channel (o, rise, fall, cnt, optional synchroniser).
  - Instantiated CHANNELS times by a generate loop.
  - all_set/all_clr reduction lives in the top module.

Test Plan:
- Reset with RST_VAL=4'b0101, a all 0:
  - o=0101, cnt=0, rise=fall=0, all_set=0, all_clr=0.
  - After release, channels 0 and 2 fall on the next edge (fall=0101, o=0000, all_clr=1).
- Channel 1, INPUTS=3:
  - a=110 -> o holds 0; a=111 -> one cycle later o[1]=1, rise[1]=1 for 1 cycle, cnt[1]=1.
  - a=011 -> hold; a=000 -> fall[1]=1, cnt[1]=2.
- en[2]=0 while a[2]=111: o[2] stays 0 with no pulse. Raising en[2] -> o[2]=1 next edge, rise[2]=1.
- Toggle channel 3 between all-1 and all-0 every cycle for 300 cycles with CNT_W=8: cnt[3] stops at 255.
  - cnt_clr[3] on a transition cycle gives cnt[3]=1.
- Drive all channels to all-1 on different cycles: all_set=1 only on the cycle the last channel's o rises.
  - Assert rst mid-sequence: outputs return to RST_VAL values next edge with no pulses.
- With C_ELEMENT_SYNC_EN defined: a[0]=111 at cycle n -> o[0]=1 and rise[0]=1 at n+3.
  - Check the same case without the macro gives n+1.
